led_matrix_scan: RTL and testbench
==================================

LED_MATRIX_SCAN -- requirements
Module: led_matrix_scan

Interface
REQ-001 SHALL have parameter ROWS, default 9, number of scanned rows (2..16).
REQ-002 SHALL have parameter COLS, default 8, number of column lines (1..32).
REQ-003 SHALL have parameter PERIOD, default 27000, row dwell time in sys_clk cycles (27 MHz gives 1 ms).
REQ-004 SHALL have parameter GAP, default 500, blanking cycles at each end of a row slot; 2*GAP < PERIOD.
REQ-005 SHALL have port sys_clk, input, 1 bit: the only clock; all logic on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port wr_en, input, 1 bit: write strobe to the back buffer.
REQ-008 SHALL have port wr_row, input, $clog2(ROWS) bits: back-buffer row address.
REQ-009 SHALL have port wr_data, input, COLS bits: row pixel data, 1 = lit.
REQ-010 SHALL have port swap_req, input, 1 bit: single-cycle request to swap buffers at the next frame boundary.
REQ-011 SHALL have port brightness, input, 4 bits: 0 = dimmest, 15 = full.
REQ-012 SHALL have port led_col, output, COLS bits: front-buffer data of the active row.
REQ-013 SHALL have port led_row, output, ROWS bits: one-hot row enable, all zero outside the on-window.
REQ-014 SHALL have port frame_start, output, 1 bit: one-cycle pulse at the start of each frame.
REQ-015 SHALL have port swap_pending, output, 1 bit: a swap is requested but not yet executed.

Function
REQ-016 cnt SHALL count 0..PERIOD-1 and wrap to 0.
REQ-017 row_idx SHALL advance on the edge where cnt wraps, and SHALL wrap from ROWS-1 to 0 for any ROWS, including non-powers of 2.
REQ-018 The brightness latch SHALL sample brightness only on edges where cnt wraps, so a change never alters a row slot already in progress.
REQ-019 on_end SHALL equal GAP + (((PERIOD-2*GAP)*(bright_latch+1)) >> 4), computed with a 32-bit intermediate.
REQ-020 The row SHALL be on when GAP <= cnt < on_end.
REQ-021 led_row and led_col SHALL be registered and SHALL reflect the cnt/row_idx state one cycle earlier.
REQ-022 led_row SHALL be (1 << row_idx) when on, else 0.
REQ-023 led_col SHALL be front[row_idx] when on, else 0.
REQ-024 Two COLS x ROWS buffers SHALL exist; a select bit sel SHALL mark which buffer is front.
REQ-025 wr_en SHALL write wr_data into back[wr_row] on the next edge.
REQ-026 A write with wr_row >= ROWS SHALL be ignored.
REQ-027 Any write SHALL leave the front buffer unchanged.
REQ-028 swap_req SHALL set swap_pending.
REQ-029 The frame boundary SHALL be the edge where cnt == PERIOD-1 and row_idx == ROWS-1.
REQ-030 At the frame boundary with swap_pending or swap_req high, sel SHALL toggle and swap_pending SHALL clear.
REQ-031 A swap SHALL NOT copy buffers: the new back buffer holds the old front buffer.
REQ-032 A write on the swap edge SHALL land in the pre-swap back buffer, which becomes front.
REQ-033 frame_start SHALL be high for exactly the one cycle in which cnt == 0 and row_idx == 0.
REQ-034 Repeated swap_req while swap_pending is high SHALL have no additional effect: one swap per boundary.

Reset
REQ-035 On rst_n low, asynchronously: cnt=0, row_idx=0, sel=0, swap_pending=0, bright_latch=15, both buffers all zero, led_row=0, led_col=0, frame_start=0.
REQ-036 After reset release, frame_start SHALL first pulse in the first cycle in which cnt==0 and row_idx==0 after at least one full frame.
REQ-037 Reset mid-frame SHALL discard any pending swap and SHALL blank the outputs immediately.

Structure
REQ-038 Package led_scan_pkg SHALL hold BRIGHT_W=4 and BRIGHT_DEFAULT=15.
REQ-039 Sub-module led_row_timer SHALL contain cnt, row_idx, the brightness latch, on-window decode and the frame-boundary/frame_start strobes.
REQ-040 Buffer and swap logic SHALL reside in led_matrix_scan.

Verification (ROWS=3, COLS=8, PERIOD=20, GAP=2)
REQ-041 Reset, then write row0=0xAA and row1=0x55, then swap_req -> after the next boundary, led_col=0xAA while led_row=3'b001, and 0x55 while 3'b010.
REQ-042 brightness=15 -> led_row high for outputs of cnt 2..17 (16 cycles); brightness=7 -> cnt 2..9 (8 cycles); a change mid-slot takes effect only on the next slot.
REQ-043 Writes without swap_req -> the display is unchanged; swap_req mid-frame -> swap_pending=1 until the boundary, then 0, and frame_start pulses the cycle after the boundary.
REQ-044 swap_req and wr_en(row2=0xFF) asserted on the boundary edge -> the swap occurs and row2 displays 0xFF in that frame.
REQ-045 wr_row=3 -> no buffer change; row_idx sequence is 0,1,2,0 with no index 3.
REQ-046 rst_n pulsed low mid-row with swap_pending=1 -> led_row=0 within the reset, swap_pending=0, and the display stays blank (all buffers zero).

Source files
------------

// File: rtl/led_scan_pkg.sv
// Shared constants and on-window arithmetic for the LED matrix scanner.
// Imported by the row timer and by the top level.
package led_scan_pkg;

    localparam int BRIGHT_W = 4;
    localparam logic [BRIGHT_W-1:0] BRIGHT_DEFAULT = 4'd15;

    // End of the lit window within a row slot; 32-bit intermediate keeps the product exact
    function automatic logic [31:0] calc_on_end(
        input int unsigned           period,
        input int unsigned           gap,
        input logic [BRIGHT_W-1:0]   bright
    );
        logic [31:0] span;
        logic [31:0] scaled;
        span   = period - (2 * gap);
        scaled = (span * (32'(bright) + 32'd1)) >> 4;
        return 32'(gap) + scaled;
    endfunction

endpackage

// File: rtl/led_row_timer.sv
// Row slot timing: dwell counter, row index, brightness latch, on-window
// decode and frame-boundary / frame_start strobes.
module led_row_timer
    import led_scan_pkg::*;
#(
    parameter int ROWS   = 9,
    parameter int PERIOD = 27000,
    parameter int GAP    = 500,
    localparam int RW    = $clog2(ROWS),
    localparam int CW    = $clog2(PERIOD)
) (
    input  logic                sys_clk,
    input  logic                rst_n,
    input  logic [BRIGHT_W-1:0] brightness,
    output logic [RW-1:0]       row_idx,
    output logic                row_on,
    output logic                frame_boundary,
    output logic                frame_start
);

    logic [CW-1:0]       cnt;
    logic [BRIGHT_W-1:0] bright_latch;
    logic                cnt_wrap;
    logic                last_row;
    logic [31:0]         on_end;

    assign cnt_wrap       = (cnt == CW'(PERIOD - 1));
    assign last_row       = (row_idx == RW'(ROWS - 1));
    assign frame_boundary = cnt_wrap && last_row;
    assign on_end         = calc_on_end(PERIOD, GAP, bright_latch);
    assign row_on         = (32'(cnt) >= 32'(GAP)) && (32'(cnt) < on_end);

    // Brightness is only resampled on slot wrap so a slot never changes width mid-flight
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt          <= '0;
            row_idx      <= '0;
            bright_latch <= BRIGHT_DEFAULT;
        end else if (cnt_wrap) begin
            cnt          <= '0;
            bright_latch <= brightness;
            row_idx      <= last_row ? '0 : row_idx + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Registered from the boundary so the pulse lands in the cnt==0,row_idx==0 cycle
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_start <= 1'b0;
        end else begin
            frame_start <= frame_boundary;
        end
    end

endmodule

// File: rtl/led_matrix_scan.sv
// Multiplexed LED matrix driver with double-buffered frame memory,
// frame-synchronous buffer swap and PWM-style row brightness.
module led_matrix_scan
    import led_scan_pkg::*;
#(
    parameter int ROWS   = 9,
    parameter int COLS   = 8,
    parameter int PERIOD = 27000,
    parameter int GAP    = 500,
    localparam int RW    = $clog2(ROWS)
) (
    input  logic                sys_clk,
    input  logic                rst_n,
    input  logic                wr_en,
    input  logic [RW-1:0]       wr_row,
    input  logic [COLS-1:0]     wr_data,
    input  logic                swap_req,
    input  logic [BRIGHT_W-1:0] brightness,
    output logic [COLS-1:0]     led_col,
    output logic [ROWS-1:0]     led_row,
    output logic                frame_start,
    output logic                swap_pending
);

    logic [RW-1:0]   row_idx;
    logic            row_on;
    logic            frame_boundary;
    logic            sel;
    logic            wr_hit;
    logic            do_swap;
    logic [COLS-1:0] front_row;
    logic [COLS-1:0] buf_a [ROWS];
    logic [COLS-1:0] buf_b [ROWS];

    led_row_timer #(
        .ROWS   (ROWS),
        .PERIOD (PERIOD),
        .GAP    (GAP)
    ) u_timer (
        .sys_clk        (sys_clk),
        .rst_n          (rst_n),
        .brightness     (brightness),
        .row_idx        (row_idx),
        .row_on         (row_on),
        .frame_boundary (frame_boundary),
        .frame_start    (frame_start)
    );

    assign wr_hit    = wr_en && (32'(wr_row) < 32'(ROWS));
    assign do_swap   = frame_boundary && (swap_pending || swap_req);
    assign front_row = sel ? buf_b[row_idx] : buf_a[row_idx];

    // sel==0: buf_a is front, buf_b is back. Writes use the pre-swap sel on a swap edge.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < ROWS; i++) begin
                buf_a[i] <= '0;
                buf_b[i] <= '0;
            end
        end else if (wr_hit) begin
            if (sel) begin
                buf_a[wr_row] <= wr_data;
            end else begin
                buf_b[wr_row] <= wr_data;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            sel          <= 1'b0;
            swap_pending <= 1'b0;
        end else if (do_swap) begin
            sel          <= ~sel;
            swap_pending <= 1'b0;
        end else if (swap_req) begin
            swap_pending <= 1'b1;
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            led_row <= '0;
            led_col <= '0;
        end else begin
            led_row <= row_on ? (ROWS'(1) << row_idx) : '0;
            led_col <= row_on ? front_row : '0;
        end
    end

endmodule

// File: tb/tb_led_matrix_scan.sv
// Directed bench for led_matrix_scan with ROWS=3, COLS=8, PERIOD=20, GAP=2.
// k counts posedges since reset release; outputs at k reflect cnt=(k-1)%20, row=((k-1)/20)%3.
module tb_led_matrix_scan;

    logic       sys_clk;
    logic       rst_n;
    logic       wr_en;
    logic [1:0] wr_row;
    logic [7:0] wr_data;
    logic       swap_req;
    logic [3:0] brightness;
    logic [7:0] led_col;
    logic [2:0] led_row;
    logic       frame_start;
    logic       swap_pending;

    int checks   = 0;
    int failures = 0;
    int k        = 0;
    int n_on;

    led_matrix_scan #(
        .ROWS   (3),
        .COLS   (8),
        .PERIOD (20),
        .GAP    (2)
    ) dut (
        .sys_clk      (sys_clk),
        .rst_n        (rst_n),
        .wr_en        (wr_en),
        .wr_row       (wr_row),
        .wr_data      (wr_data),
        .swap_req     (swap_req),
        .brightness   (brightness),
        .led_col      (led_col),
        .led_row      (led_row),
        .frame_start  (frame_start),
        .swap_pending (swap_pending)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s k=%0d got=%0h exp=%0h", tag, k, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
        k++;
    endtask

    task automatic run_to(input int target);
        while (k < target) tick();
    endtask

    task automatic write_row(input logic [1:0] row, input logic [7:0] data);
        wr_en   = 1'b1;
        wr_row  = row;
        wr_data = data;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic pulse_swap();
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
    endtask

    // Counts lit cycles over one 20-cycle slot, changing brightness part way through
    task automatic count_slot(input int chg_at, input logic [3:0] new_b, output int n);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (i == chg_at) brightness = new_b;
            tick();
            if (led_row != 3'b000) n++;
        end
    endtask

    task automatic check_disp(input string tag, input int at, input logic [2:0] row, input logic [7:0] col);
        run_to(at);
        check_eq({tag, "_row"}, 32'(led_row), 32'(row));
        check_eq({tag, "_col"}, 32'(led_col), 32'(col));
    endtask

    initial begin
        rst_n      = 1'b0;
        wr_en      = 1'b0;
        wr_row     = '0;
        wr_data    = '0;
        swap_req   = 1'b0;
        brightness = 4'd15;
        repeat (2) @(posedge sys_clk);
        #1;
        check_eq("rst_led_row", 32'(led_row), 32'h0);
        check_eq("rst_led_col", 32'(led_col), 32'h0);
        check_eq("rst_frame_start", 32'(frame_start), 32'h0);
        check_eq("rst_swap_pending", 32'(swap_pending), 32'h0);
        rst_n = 1'b1;
        k = 0;

        // Fill back buffer and request swap; front stays blank for frame 0
        write_row(2'd0, 8'hAA);
        write_row(2'd1, 8'h55);
        pulse_swap();
        check_eq("pending_set", 32'(swap_pending), 32'h1);
        check_disp("f0_blank", 5, 3'b001, 8'h00);
        run_to(59);
        check_eq("f0_pending_hold", 32'(swap_pending), 32'h1);
        check_eq("f0_fs_low", 32'(frame_start), 32'h0);
        run_to(60);
        check_eq("f1_fs_pulse", 32'(frame_start), 32'h1);
        check_eq("f1_pending_clr", 32'(swap_pending), 32'h0);

        // Brightness: change mid-slot only affects the next slot
        count_slot(5, 4'd7, n_on);
        check_eq("bright15_slot", 32'(n_on), 32'd16);
        count_slot(5, 4'd15, n_on);
        check_eq("bright7_slot", 32'(n_on), 32'd8);
        count_slot(99, 4'd15, n_on);
        check_eq("bright_restore", 32'(n_on), 32'd16);
        check_eq("f2_fs_pulse", 32'(frame_start), 32'h1);

        // Write without swap leaves the display alone
        write_row(2'd0, 8'h0F);
        check_disp("f2_pre_gap", 122, 3'b000, 8'h00);
        check_disp("f2_row0", 123, 3'b001, 8'hAA);
        pulse_swap();
        check_eq("f2_pending_set", 32'(swap_pending), 32'h1);
        check_disp("f2_row0_last", 138, 3'b001, 8'hAA);
        check_disp("f2_row0_off", 139, 3'b000, 8'h00);
        pulse_swap();
        check_disp("f2_row1", 143, 3'b010, 8'h55);
        check_disp("f2_row2", 163, 3'b100, 8'h00);
        run_to(179);
        check_eq("f2_pending_hold", 32'(swap_pending), 32'h1);
        run_to(180);
        check_eq("f3_fs_pulse", 32'(frame_start), 32'h1);
        check_eq("f3_pending_clr", 32'(swap_pending), 32'h0);
        run_to(181);
        check_eq("f3_fs_one_cycle", 32'(frame_start), 32'h0);
        check_disp("f3_row0", 183, 3'b001, 8'h0F);
        check_disp("f3_row1", 203, 3'b010, 8'h00);
        run_to(239);
        check_eq("f3_no_extra_swap", 32'(swap_pending), 32'h0);

        // Swap and write on the same boundary edge
        swap_req = 1'b1;
        wr_en    = 1'b1;
        wr_row   = 2'd2;
        wr_data  = 8'hFF;
        tick();
        swap_req = 1'b0;
        wr_en    = 1'b0;
        check_eq("f4_pending_clr", 32'(swap_pending), 32'h0);
        check_disp("f4_row0", 243, 3'b001, 8'hAA);
        check_disp("f4_row1", 263, 3'b010, 8'h55);
        check_disp("f4_row2", 283, 3'b100, 8'hFF);

        // Out-of-range row write is dropped
        run_to(290);
        write_row(2'd3, 8'h33);
        pulse_swap();
        check_disp("f5_row0", 303, 3'b001, 8'h0F);
        check_disp("f5_row1", 323, 3'b010, 8'h00);
        check_disp("f5_row2", 343, 3'b100, 8'h00);
        check_disp("f6_row0", 363, 3'b001, 8'h0F);

        // Asynchronous reset mid-row with a swap pending
        pulse_swap();
        check_eq("pre_rst_pending", 32'(swap_pending), 32'h1);
        check_disp("pre_rst_lit", 370, 3'b001, 8'h0F);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_led_row", 32'(led_row), 32'h0);
        check_eq("arst_led_col", 32'(led_col), 32'h0);
        check_eq("arst_pending", 32'(swap_pending), 32'h0);
        check_eq("arst_fs", 32'(frame_start), 32'h0);
        @(posedge sys_clk);
        #1;
        rst_n = 1'b1;
        k = 0;
        run_to(1);
        check_eq("post_rst_fs_low", 32'(frame_start), 32'h0);
        check_disp("post_rst_row0", 3, 3'b001, 8'h00);
        run_to(10);
        pulse_swap();
        run_to(60);
        check_eq("post_rst_fs_pulse", 32'(frame_start), 32'h1);
        check_eq("post_rst_pending_clr", 32'(swap_pending), 32'h0);
        check_disp("post_rst_f1_row0", 63, 3'b001, 8'h00);
        check_disp("post_rst_f1_row1", 83, 3'b010, 8'h00);
        check_disp("post_rst_f1_row2", 103, 3'b100, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
